// File: rtl/apb_xfer_arbiter.sv
// Shares one APB master between NREQ requesters: grants one request at a time, drives the
// master's S-side payload/transfer, and returns completion. Define APB_ARB_FIXED_PRIO_EN for fixed priority.
module apb_xfer_arbiter #(
   parameter int NREQ = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_write,
   input  logic [NREQ*32-1:0] req_addr,
   input  logic [NREQ*32-1:0] req_wdata,
   input  logic [NREQ*4-1:0] req_strb,
   input  logic [NREQ*3-1:0] req_prot,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_slverr,
   output logic              SWRITE,
   output logic [31:0]       SADDR,
   output logic [31:0]       SWDATA,
   output logic [3:0]        SSTRB,
   output logic [2:0]        SPROT,
   output logic              transfer,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic [31:0]       PRDATA
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {ARB, ISSUE, BUSY, RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic            swrite_q, swrite_d;
   logic [31:0]     saddr_q, saddr_d;
   logic [31:0]     swdata_q, swdata_d;
   logic [3:0]      sstrb_q, sstrb_d;
   logic [2:0]      sprot_q, sprot_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            slverr_q, slverr_d;
`ifndef APB_ARB_FIXED_PRIO_EN
   logic [IW-1:0]   ptr_q, ptr_d;
`endif

   logic            found;
   logic [IW-1:0]   win;

   // First valid requester found when scanning upward from the search start, wrapping at NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
         idx = k;
`else
         idx = (int'(ptr_q) + k) % NREQ;
`endif
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_comb begin
      int wi;
      wi         = int'(win);
      state_d    = state_q;
      owner_d    = owner_q;
      swrite_d   = swrite_q;
      saddr_d    = saddr_q;
      swdata_d   = swdata_q;
      sstrb_d    = sstrb_q;
      sprot_d    = sprot_q;
      rdata_d    = rdata_q;
      slverr_d   = slverr_q;
`ifndef APB_ARB_FIXED_PRIO_EN
      ptr_d      = ptr_q;
`endif
      req_ready  = '0;
      rsp_valid  = '0;
      transfer   = 1'b0;
      case (state_q)
         ARB: begin
            if (found) begin
               req_ready[win] = 1'b1;
               owner_d        = win;
               swrite_d       = req_write[win];
               saddr_d        = req_addr[wi*32 +: 32];
               swdata_d       = req_wdata[wi*32 +: 32];
               sstrb_d        = req_strb[wi*4 +: 4];
               sprot_d        = req_prot[wi*3 +: 3];
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            transfer = 1'b1;
            state_d  = BUSY;
         end
         BUSY: begin
            if (PSEL && PENABLE && PREADY) begin
               // Writes return zero so stale read data never leaks to a writer.
               rdata_d  = swrite_q ? 32'd0 : PRDATA;
               slverr_d = PSLVERR;
               state_d  = RESP;
            end
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
`ifndef APB_ARB_FIXED_PRIO_EN
            ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
`endif
            state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= ARB;
         owner_q  <= '0;
         swrite_q <= 1'b0;
         saddr_q  <= '0;
         swdata_q <= '0;
         sstrb_q  <= '0;
         sprot_q  <= '0;
         rdata_q  <= '0;
         slverr_q <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
         ptr_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         swrite_q <= swrite_d;
         saddr_q  <= saddr_d;
         swdata_q <= swdata_d;
         sstrb_q  <= sstrb_d;
         sprot_q  <= sprot_d;
         rdata_q  <= rdata_d;
         slverr_q <= slverr_d;
`ifndef APB_ARB_FIXED_PRIO_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign SWRITE     = swrite_q;
   assign SADDR      = saddr_q;
   assign SWDATA     = swdata_q;
   assign SSTRB      = sstrb_q;
   assign SPROT      = sprot_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_slverr = slverr_q;

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// Directed bench for apb_xfer_arbiter (NREQ=2); the bench plays the APB master/slave handshake.
module tb_apb_xfer_arbiter;

   localparam logic [31:0] A0 = 32'h1000_0004, D0 = 32'hDEAD_BEEF;
   localparam logic [31:0] A1 = 32'h2000_0000, D1 = 32'h5555_AAAA;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_strb;
   logic [5:0]  req_prot;
   logic [31:0] rsp_rdata, SADDR, SWDATA, PRDATA;
   logic        rsp_slverr, SWRITE, transfer, PSEL, PENABLE, PREADY, PSLVERR;
   logic [3:0]  SSTRB;
   logic [2:0]  SPROT;

   int pass_cnt = 0;
   int total    = 0;

   apb_xfer_arbiter #(.NREQ(2)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .SWRITE(SWRITE), .SADDR(SADDR), .SWDATA(SWDATA),
      .SSTRB(SSTRB), .SPROT(SPROT), .transfer(transfer),
      .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic bus_idle();
      PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PRDATA = 32'hFFFF_FFFF;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {30'd0, req_ready}, 0);
      chk({tag, "_rspv"}, {30'd0, rsp_valid}, 0);
      chk({tag, "_rdata"}, rsp_rdata, 0);
      chk({tag, "_slverr"}, {31'd0, rsp_slverr}, 0);
      chk({tag, "_xfer"}, {31'd0, transfer}, 0);
      chk({tag, "_swrite"}, {31'd0, SWRITE}, 0);
      chk({tag, "_saddr"}, SADDR, 0);
      chk({tag, "_swdata"}, SWDATA, 0);
      chk({tag, "_sstrb"}, {28'd0, SSTRB}, 0);
      chk({tag, "_sprot"}, {29'd0, SPROT}, 0);
   endtask

   // One transfer starting in an ARB cycle (C0) and ending in the following ARB cycle.
   task automatic xfer(input logic [1:0] vmask, input int ew, input int waits,
                       input logic [31:0] prd, input logic err, input logic [31:0] exp_rd,
                       input logic keep, input logic pulse);
      logic [31:0] ea;
      ea = (ew == 0) ? A0 : A1;
      req_valid = vmask;
      #1;
      chk("grant", {30'd0, req_ready}, 32'd1 << ew);
      chk("c0_xfer", {31'd0, transfer}, 0);
      cyc();
      if (!keep) req_valid = 2'b00;
      #1;
      chk("c1_xfer", {31'd0, transfer}, 1);
      chk("c1_ready", {30'd0, req_ready}, 0);
      chk("c1_saddr", SADDR, ea);
      chk("c1_swdata", SWDATA, (ew == 0) ? D0 : D1);
      chk("c1_swrite", {31'd0, SWRITE}, (ew == 0) ? 1 : 0);
      chk("c1_sstrb", {28'd0, SSTRB}, (ew == 0) ? 32'hF : 32'h3);
      chk("c1_sprot", {29'd0, SPROT}, (ew == 0) ? 32'h0 : 32'h5);
      cyc();
      PSEL = 1;
      if (pulse) req_valid = 2'b10;
      #1;
      chk("setup_xfer", {31'd0, transfer}, 0);
      chk("setup_ready", {30'd0, req_ready}, 0);
      chk("setup_saddr", SADDR, ea);
      for (int i = 0; i < waits; i++) begin
         cyc();
         if (pulse) req_valid = 2'b00;
         PENABLE = 1; PREADY = 0; PSLVERR = 1; PRDATA = 32'hBAD0_0000;
         #1;
         chk("wait_rspv", {30'd0, rsp_valid}, 0);
      end
      cyc();
      if (pulse) req_valid = 2'b00;
      PENABLE = 1; PREADY = 1; PRDATA = prd; PSLVERR = err;
      #1;
      chk("acc_saddr", SADDR, ea);
      chk("acc_rspv", {30'd0, rsp_valid}, 0);
      chk("acc_ready", {30'd0, req_ready}, 0);
      cyc();
      bus_idle();
      #1;
      chk("rsp_valid", {30'd0, rsp_valid}, 32'd1 << ew);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_slverr", {31'd0, rsp_slverr}, {31'd0, err});
      chk("rsp_xfer", {31'd0, transfer}, 0);
      cyc();
      chk("c5_rspv", {30'd0, rsp_valid}, 0);
      chk("c5_rdata_hold", rsp_rdata, exp_rd);
   endtask

   initial begin
      int ew;
      logic [31:0] prd;
      PRESETn   = 0;
      req_valid = 0;
      req_write = 2'b01;
      req_addr  = {A1, A0};
      req_wdata = {D1, D0};
      req_strb  = {4'h3, 4'hF};
      req_prot  = {3'h5, 3'h0};
      bus_idle();
      #3;
      chk_all_zero("reset");
      #9 PRESETn = 1;
      cyc();

      // Single write, then a read with three wait states.
      xfer(2'b01, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(2'b10, 1, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0);

      // Contention: both requesters hold valid through four back-to-back transfers.
      for (int i = 0; i < 4; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
         ew = 0;
`else
         ew = i % 2;
`endif
         prd = 32'hA0A0_0000 + i;
         xfer(2'b11, ew, 0, prd, 1'b0, (ew == 0) ? 32'h0 : prd, 1'b1, 1'b0);
      end
      req_valid = 2'b00;
      cyc();

      // Slave error on a write.
      xfer(2'b01, 0, 0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

      // Reset while requester 1 is in BUSY.
      req_valid = 2'b10;
      #1;
      chk("rst_grant", {30'd0, req_ready}, 32'd2);
      cyc();
      req_valid = 2'b00;
      cyc();
      PSEL = 1;
      #2 PRESETn = 0;
      #1;
      chk_all_zero("midrst");
      cyc();
      PENABLE = 1; PREADY = 1;
      #2 PRESETn = 1;
      cyc();
      bus_idle();
      #1;
      chk("postrst_rspv", {30'd0, rsp_valid}, 0);
      chk("postrst_xfer", {31'd0, transfer}, 0);
      cyc();
      chk("postrst_rspv2", {30'd0, rsp_valid}, 0);
      // ptr must be back at 0, so requester 0 wins; error flag clears on the next transfer.
      xfer(2'b11, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Requester 1 pulses valid for one cycle while requester 0 is busy.
      xfer(2'b01, 0, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("wd_ready", {30'd0, req_ready}, 0);
      cyc();
      chk("wd_xfer", {31'd0, transfer}, 0);
      chk("wd_rspv", {30'd0, rsp_valid}, 0);
      cyc();
      chk("wd_xfer2", {31'd0, transfer}, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
